// File: rtl/vliw_pkg.sv
// Shared types for the VLIW memory-slot scheduler.
// State encoding, default widths and the memory request bundle.
package vliw_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int RD_W   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLOT3 = 2'd1,
        SLOT4 = 2'd2,
        DONE  = 2'd3
    } mem_sched_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/vliw_mem_sched.sv
// Serialises the two memory slots of a VLIW bundle onto one memory port.
// Stalls the pipeline until both accesses finish; returns load data to WB.
module vliw_mem_sched #(
    parameter int ADDR_W = vliw_pkg::ADDR_W,
    parameter int DATA_W = vliw_pkg::DATA_W,
    parameter int RD_W   = vliw_pkg::RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              mre3,
    input  logic              mwe3,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [DATA_W-1:0] wdata3,
    input  logic [RD_W-1:0]   rd3,
    input  logic              mre4,
    input  logic              mwe4,
    input  logic [ADDR_W-1:0] addr4,
    input  logic [DATA_W-1:0] wdata4,
    input  logic [RD_W-1:0]   rd4,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              mem_stall,
    output logic [RD_W-1:0]   wb_rd3,
    output logic [RD_W-1:0]   wb_rd4,
    output logic [DATA_W-1:0] wb_memdata3,
    output logic [DATA_W-1:0] wb_memdata4
);
    import vliw_pkg::*;

    mem_sched_state_t state_q, state_d;

    logic [DATA_W-1:0] data3_q, data3_d;
    logic [DATA_W-1:0] data4_q, data4_d;
    logic [RD_W-1:0]   wb_rd3_q, wb_rd3_d;
    logic [RD_W-1:0]   wb_rd4_q, wb_rd4_d;
    logic [DATA_W-1:0] wb_md3_q, wb_md3_d;
    logic [DATA_W-1:0] wb_md4_q, wb_md4_d;

    logic     op3, op4;
    logic     sel4, req, complete, adv;
    logic     ack3, ack4;
    mem_req_t req_sel;

    assign op3 = mre3 | mwe3;
    assign op4 = mre4 | mwe4;

    // Next state, slot select and completion; a load wins over a store.
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        sel4     = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                sel4 = !op3;
                req  = op3 | op4;
                if (!(op3 | op4)) begin
                    complete = 1'b1;
                end else if (m_ack) begin
                    if (op3 && op4) begin
                        state_d = SLOT4;
                    end else begin
                        complete = 1'b1;
                        state_d  = stall ? DONE : IDLE;
                    end
                end else begin
                    state_d = op3 ? SLOT3 : SLOT4;
                end
            end
            SLOT3: begin
                req = 1'b1;
                if (m_ack) begin
                    if (op4) begin
                        state_d = SLOT4;
                    end else begin
                        complete = 1'b1;
                        state_d  = stall ? DONE : IDLE;
                    end
                end
            end
            SLOT4: begin
                req  = 1'b1;
                sel4 = 1'b1;
                if (m_ack) begin
                    complete = 1'b1;
                    state_d  = stall ? DONE : IDLE;
                end
            end
            DONE: begin
                complete = 1'b1;
                if (!stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot mux, port drive, load capture and writeback next values.
    always_comb begin
        req_sel.we    = sel4 ? (mwe4 & !mre4) : (mwe3 & !mre3);
        req_sel.addr  = sel4 ? addr4 : addr3;
        req_sel.wdata = sel4 ? wdata4 : wdata3;

        m_req     = req & !rst;
        m_we      = req_sel.we & !rst;
        m_addr    = rst ? '0 : req_sel.addr;
        m_wdata   = rst ? '0 : req_sel.wdata;
        mem_stall = !complete & !rst;

        adv  = complete & !stall;
        ack3 = req & m_ack & !sel4;
        ack4 = req & m_ack & sel4;

        data3_d = ack3 ? m_rdata : data3_q;
        data4_d = ack4 ? m_rdata : data4_q;

        wb_rd3_d = adv ? {mre3, rd3[RD_W-2:0]} : '0;
        wb_rd4_d = adv ? {mre4, rd4[RD_W-2:0]} : '0;
        wb_md3_d = (adv && mre3) ? data3_d : '0;
        wb_md4_d = (adv && mre4) ? data4_d : '0;
    end

    // State, load holding and writeback registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            data3_q  <= '0;
            data4_q  <= '0;
            wb_rd3_q <= '0;
            wb_rd4_q <= '0;
            wb_md3_q <= '0;
            wb_md4_q <= '0;
        end else begin
            state_q  <= state_d;
            data3_q  <= data3_d;
            data4_q  <= data4_d;
            wb_rd3_q <= wb_rd3_d;
            wb_rd4_q <= wb_rd4_d;
            wb_md3_q <= wb_md3_d;
            wb_md4_q <= wb_md4_d;
        end
    end

    assign wb_rd3      = wb_rd3_q;
    assign wb_rd4      = wb_rd4_q;
    assign wb_memdata3 = wb_md3_q;
    assign wb_memdata4 = wb_md4_q;

endmodule

// File: tb/tb_vliw_mem_sched.sv
// Directed bench for vliw_mem_sched with a small memory and ack model.
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_vliw_mem_sched;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        mre3, mwe3, mre4, mwe4;
    logic [29:0] addr3, addr4;
    logic [31:0] wdata3, wdata4;
    logic [6:0]  rd3, rd4;
    logic        m_req, m_we, m_ack;
    logic [29:0] m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic        mem_stall;
    logic [6:0]  wb_rd3, wb_rd4;
    logic [31:0] wb_memdata3, wb_memdata4;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [256];
    int unsigned wait_cnt = 0;
    int unsigned ack_delay;
    logic        ack_force;

    vliw_mem_sched dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mre3(mre3), .mwe3(mwe3), .addr3(addr3),
        .wdata3(wdata3), .rd3(rd3),
        .mre4(mre4), .mwe4(mwe4), .addr4(addr4),
        .wdata4(wdata4), .rd4(rd4),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
        .mem_stall(mem_stall),
        .wb_rd3(wb_rd3), .wb_rd4(wb_rd4),
        .wb_memdata3(wb_memdata3), .wb_memdata4(wb_memdata4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_rdata = mem[m_addr[7:0]];
    assign m_ack = ack_force | (m_req && (wait_cnt == ack_delay));

    always @(posedge clk) begin
        if (m_req && !m_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 16) ? 32'hDEADBEEF : 32'h0;
        end else if (m_req && m_ack && m_we) begin
            mem[m_addr[7:0]] <= m_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear;
        mre3 = 0; mwe3 = 0; addr3 = '0; wdata3 = '0; rd3 = '0;
        mre4 = 0; mwe4 = 0; addr4 = '0; wdata4 = '0; rd4 = '0;
    endtask

    int nstall;
    int nbad;

    initial begin
        clear();
        rst = 1; stall = 0; ack_delay = 0; ack_force = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mre3 = 1; addr3 = 30'h10;
        #1;
        chk("rst_req", m_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_wb_rd3", wb_rd3, 0);
        chk("rst_wb_md4", wb_memdata4, 0);
        clear();
        step();
        rst = 0;

        // single load, immediate ack
        mre3 = 1; addr3 = 30'h10; rd3 = 7'h05;
        @(negedge clk);
        chk("t1_req", m_req, 1);
        chk("t1_stall", mem_stall, 0);
        chk("t1_addr", m_addr, 32'h10);
        step(); clear();
        @(negedge clk);
        chk("t1_wb_rd3", wb_rd3, 7'h45);
        chk("t1_wb_md3", wb_memdata3, 32'hDEADBEEF);
        chk("t1_wb_rd4", wb_rd4, 0);
        step();
        @(negedge clk);
        chk("t1_bubble", wb_rd3, 0);
        step();

        // store slot 3 then load slot 4, same address
        mwe3 = 1; addr3 = 30'h20; wdata3 = 32'h1234;
        mre4 = 1; addr4 = 30'h20; rd4 = 7'h07;
        @(negedge clk);
        chk("t2_we_a", m_we, 1);
        chk("t2_stall_a", mem_stall, 1);
        chk("t2_wdata", m_wdata, 32'h1234);
        step();
        @(negedge clk);
        chk("t2_we_b", m_we, 0);
        chk("t2_stall_b", mem_stall, 0);
        chk("t2_early_rd4", wb_rd4, 0);
        step(); clear();
        @(negedge clk);
        chk("t2_wb_rd4", wb_rd4, 7'h47);
        chk("t2_wb_md4", wb_memdata4, 32'h1234);
        chk("t2_wb_rd3", wb_rd3, 0);
        chk("t2_wb_md3", wb_memdata3, 0);
        step();

        // slot 4 only, one wait cycle
        ack_delay = 1;
        mre4 = 1; addr4 = 30'h10; rd4 = 7'h01;
        @(negedge clk);
        chk("t2b_req", m_req, 1);
        chk("t2b_addr", m_addr, 32'h10);
        chk("t2b_stall_a", mem_stall, 1);
        step();
        @(negedge clk);
        chk("t2b_stall_b", mem_stall, 0);
        step(); clear();
        @(negedge clk);
        chk("t2b_wb_rd4", wb_rd4, 7'h41);
        chk("t2b_wb_md4", wb_memdata4, 32'hDEADBEEF);
        chk("t2b_wb_rd3", wb_rd3, 0);
        step();

        // two loads, three wait cycles each
        ack_delay = 3;
        mre3 = 1; addr3 = 30'h10; rd3 = 7'h11;
        mre4 = 1; addr4 = 30'h20; rd4 = 7'h12;
        nstall = 0; nbad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_stall) nstall++;
            if (wb_rd3 != 0 || wb_rd4 != 0) nbad++;
            step();
        end
        clear();
        chk("t3_stall_cycles", nstall, 7);
        chk("t3_early_wb", nbad, 0);
        @(negedge clk);
        chk("t3_wb_rd3", wb_rd3, 7'h51);
        chk("t3_wb_md3", wb_memdata3, 32'hDEADBEEF);
        chk("t3_wb_rd4", wb_rd4, 7'h52);
        chk("t3_wb_md4", wb_memdata4, 32'h1234);
        step();

        // completion under external stall
        ack_delay = 0; stall = 1;
        mre3 = 1; addr3 = 30'h20; rd3 = 7'h2A;
        @(negedge clk);
        chk("t4_req", m_req, 1);
        chk("t4_stall", mem_stall, 0);
        step();
        nbad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m_req || mem_stall || wb_rd3 != 0) nbad++;
            step();
        end
        chk("t4_done_hold", nbad, 0);
        stall = 0;
        @(negedge clk);
        chk("t4_done_req", m_req, 0);
        chk("t4_done_wb", wb_rd3, 0);
        step(); clear();
        @(negedge clk);
        chk("t4_wb_rd3", wb_rd3, 7'h6A);
        chk("t4_wb_md3", wb_memdata3, 32'h1234);
        step();

        // reset while slot 4 is outstanding
        ack_delay = 2;
        mre3 = 1; addr3 = 30'h10; rd3 = 7'h01;
        mre4 = 1; addr4 = 30'h10; rd4 = 7'h02;
        repeat (3) step();
        @(negedge clk);
        chk("t5_req_pre", m_req, 1);
        chk("t5_stall_pre", mem_stall, 1);
        rst = 1;
        #1;
        chk("t5_req_rst", m_req, 0);
        chk("t5_stall_rst", mem_stall, 0);
        chk("t5_addr_rst", m_addr, 0);
        chk("t5_wb_rst", wb_rd3, 0);
        clear();
        step();
        rst = 0;
        ack_delay = 0;
        mre3 = 1; addr3 = 30'h10; rd3 = 7'h04;
        addr4 = 30'h33;
        @(negedge clk);
        chk("t5_idle_addr", m_addr, 32'h10);
        chk("t5_idle_stall", mem_stall, 0);
        step(); clear();
        @(negedge clk);
        chk("t5_wb_rd3", wb_rd3, 7'h44);
        chk("t5_wb_md3", wb_memdata3, 32'hDEADBEEF);
        step();

        // empty bundle, then load+store on one slot
        @(negedge clk);
        chk("t6_empty_req", m_req, 0);
        chk("t6_empty_stall", mem_stall, 0);
        step();
        mre3 = 1; mwe3 = 1; addr3 = 30'h10;
        wdata3 = 32'hFFFF0000; rd3 = 7'h03;
        @(negedge clk);
        chk("t6_req", m_req, 1);
        chk("t6_we", m_we, 0);
        step(); clear();
        @(negedge clk);
        chk("t6_wb_rd3", wb_rd3, 7'h43);
        chk("t6_wb_md3", wb_memdata3, 32'hDEADBEEF);
        step();

        // stray ack with no request
        ack_force = 1;
        @(negedge clk);
        chk("t7_req", m_req, 0);
        chk("t7_stall", mem_stall, 0);
        step();
        ack_force = 0;
        @(negedge clk);
        chk("t7_wb_md3", wb_memdata3, 0);
        chk("t7_mem", mem[8'h10], 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
